regfile_mp: RTL and testbench

Parametrised multi-port integer register file with per-register scoreboard, the successor to the single-write/dual-read datapath register file. It provides NRD combinational read ports, NWR write ports with write-through bypass and fixed write priority, an optional hardwired zero register, synchronous clear, and a busy bit per register. Decode reserves destinations and writeback clears them. It sits in the datapath between decode (reads, reservations) and writeback (writes); hazard logic consumes `rd_busy` and `busy_cnt`.

---
 rtl/regfile_mp.sv | 140 ++++++++++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register scoreboard.
// NRD combinational read ports with write-through bypass, NWR write ports
// (highest-index port wins on address collision), an optional hardwired zero
// register, and one busy bit per register. Decode sets busy bits through the
// reservation port. Writeback clears them by writing the register.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [CW-1:0]       busy_cnt
);

  // An address names real, writable storage: it is in range and is not the
  // hardwired zero register. Everything else is dropped on write/reserve and
  // reads back as zero and not busy.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic ok;
    ok = (32'(a) < NREGS);
    if ((ZERO_REG != 0) && (a == '0)) ok = 1'b0;
    return ok;
  endfunction

  logic [XLEN-1:0] regs_reg [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [CW-1:0]    busy_cnt_reg;
  logic [CW-1:0]    busy_cnt_next;

  logic [AW-1:0]    wa [NWR];
  logic [XLEN-1:0]  wd [NWR];
  logic [NWR-1:0]   wv;
  logic             rsv_ok;

  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_dat [NREGS];

  // Unpack write ports and qualify each enable against the address.
  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wport
      assign wa[gi] = wr_addr[gi*AW +: AW];
      assign wd[gi] = wr_data[gi*XLEN +: XLEN];
      assign wv[gi] = wr_en[gi] & addr_ok(wa[gi]);
    end
  endgenerate

  assign rsv_ok = rsv_en & addr_ok(rsv_addr);

  // Per-register write decode (later ports overwrite earlier ones, so the
  // highest-index port wins), next busy vector, and its population count.
  always_comb begin
    busy_cnt_next = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_dat[r] = '0;
      for (int k = 0; k < NWR; k++) begin
        if (wv[k] && (wa[k] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_dat[r] = wd[k];
        end
      end
      // A new reservation beats a same-cycle write: the new producer is pending.
      if (rsv_ok && (rsv_addr == AW'(r)))
        busy_next[r] = 1'b1;
      else if (wr_hit[r])
        busy_next[r] = 1'b0;
      else
        busy_next[r] = busy_reg[r];
      busy_cnt_next = busy_cnt_next + CW'(busy_next[r]);
    end
  end

  // Storage, scoreboard and busy count; reset discards same-cycle requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_reg[r] <= '0;
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) regs_reg[r] <= wr_dat[r];
      end
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign busy_cnt = busy_cnt_reg;

  // Read ports: bypass from this cycle's writes, else storage; a same-cycle
  // write to the addressed register also masks its busy bit.
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rport
      logic [AW-1:0]   ra;
      logic            byp_hit;
      logic [XLEN-1:0] byp_dat;
      logic [XLEN-1:0] rdat;
      logic            rbusy;

      assign ra = rd_addr[gi*AW +: AW];

      // Select bypass data, storage data, or zero for this port.
      always_comb begin
        byp_hit = 1'b0;
        byp_dat = '0;
        for (int k = 0; k < NWR; k++) begin
          if (wv[k] && (wa[k] == ra)) begin
            byp_hit = 1'b1;
            byp_dat = wd[k];
          end
        end
        rdat  = '0;
        rbusy = 1'b0;
        if (!rst && addr_ok(ra)) begin
          rdat  = byp_hit ? byp_dat : regs_reg[ra];
          rbusy = busy_reg[ra] & ~byp_hit;
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = rdat;
      assign rd_busy[gi]              = rbusy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (defaults: 32x32, 2R/2W, zero reg).
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;
  localparam int CW = 6;

  logic                clk;
  logic                rst;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [CW-1:0]       busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[port]             = 1'b1;
    wr_addr[port*AW +: AW]  = a;
    wr_data[port*XLEN +: XLEN] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    rd_addr[port*AW +: AW] = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; rsv_en = 1'b0; rsv_addr = '0;

    // Reset: bypass suppressed while rst is high
    cyc();
    wr(0, 5'd5, 32'h0000_1234); rd(0, 5'd5); rd(1, 5'd5);
    #1;
    chk("rst_rd0_bypass_off", rd_data[31:0], 32'h0);
    chk("rst_busy", 32'(rd_busy), 32'h0);
    cyc();
    rst = 1'b0; idle();
    #1;
    chk("post_rst_r5", rd_data[31:0], 32'h0);
    chk("post_rst_cnt", 32'(busy_cnt), 32'h0);

    // Reset mid-operation discards state and same-cycle requests
    wr(0, 5'd5, 32'hDEAD_BEEF);
    cyc(); idle();
    rsv(5'd7);
    cyc(); idle();
    rd(0, 5'd5); rd(1, 5'd7);
    #1;
    chk("pre_rst_r5", rd_data[31:0], 32'hDEAD_BEEF);
    chk("pre_rst_r7_busy", 32'(rd_busy[1]), 32'h1);
    chk("pre_rst_cnt", 32'(busy_cnt), 32'h1);
    rst = 1'b1; wr(0, 5'd5, 32'h0000_1111); rsv(5'd8);
    #1;
    chk("in_rst_rd0", rd_data[31:0], 32'h0);
    cyc();
    rst = 1'b0; idle();
    #1;
    chk("rst_r5_cleared", rd_data[31:0], 32'h0);
    chk("rst_r7_not_busy", 32'(rd_busy[1]), 32'h0);
    chk("rst_cnt_zero", 32'(busy_cnt), 32'h0);

    // Bypass and write priority: port1 beats port0 on r3
    wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); rd(0, 5'd3);
    #1;
    chk("prio_bypass_r3", rd_data[31:0], 32'h22);
    cyc(); idle();
    #1;
    chk("prio_stored_r3", rd_data[31:0], 32'h22);

    // Two ports to distinct registers, both read ports bypassing
    wr(0, 5'd10, 32'h0000_000A); wr(1, 5'd11, 32'h0000_000B);
    rd(0, 5'd10); rd(1, 5'd11);
    #1;
    chk("byp_r10", rd_data[31:0], 32'hA);
    chk("byp_r11", rd_data[63:32], 32'hB);
    cyc(); idle();
    #1;
    chk("stored_r10", rd_data[31:0], 32'hA);
    chk("stored_r11", rd_data[63:32], 32'hB);

    // Zero register ignores writes and reservations
    wr(0, 5'd0, 32'hFFFF_FFFF); rsv(5'd0); rd(0, 5'd0);
    #1;
    chk("zero_byp", rd_data[31:0], 32'h0);
    chk("zero_busy_now", 32'(rd_busy[0]), 32'h0);
    cyc(); idle();
    #1;
    chk("zero_stored", rd_data[31:0], 32'h0);
    chk("zero_busy_next", 32'(rd_busy[0]), 32'h0);
    chk("zero_cnt", 32'(busy_cnt), 32'h0);

    // Scoreboard: reserve r9 in cycle 0, write in cycle 3
    rsv(5'd9); rd(0, 5'd9);
    #1;
    chk("sb_c0_not_yet_busy", 32'(rd_busy[0]), 32'h0);
    cyc(); idle();
    #1;
    chk("sb_c1_busy", 32'(rd_busy[0]), 32'h1);
    chk("sb_c1_cnt", 32'(busy_cnt), 32'h1);
    cyc();
    cyc();
    wr(1, 5'd9, 32'h55);
    #1;
    chk("sb_c3_busy_masked", 32'(rd_busy[0]), 32'h0);
    chk("sb_c3_data", rd_data[31:0], 32'h55);
    chk("sb_c3_cnt", 32'(busy_cnt), 32'h1);
    cyc(); idle();
    #1;
    chk("sb_c4_cnt", 32'(busy_cnt), 32'h0);
    chk("sb_c4_data", rd_data[31:0], 32'h55);

    // Reserve and write r4 in the same cycle: new data, stays busy
    rsv(5'd4); wr(0, 5'd4, 32'h44); rd(0, 5'd4);
    #1;
    chk("rw_r4_busy_now", 32'(rd_busy[0]), 32'h0);
    chk("rw_r4_byp", rd_data[31:0], 32'h44);
    cyc(); idle();
    #1;
    chk("rw_r4_data", rd_data[31:0], 32'h44);
    chk("rw_r4_busy", 32'(rd_busy[0]), 32'h1);
    chk("rw_r4_cnt", 32'(busy_cnt), 32'h1);
    wr(0, 5'd4, 32'h45);
    cyc(); idle();
    #1;
    chk("r4_clear_cnt", 32'(busy_cnt), 32'h0);

    // Full scoreboard: reserve r1..r31 on consecutive cycles
    for (int i = 1; i < 32; i++) begin
      idle(); rsv(5'(i));
      cyc();
      if (i == 16) begin
        #1;
        chk("full_cnt_16", 32'(busy_cnt), 32'd16);
      end
    end
    idle();
    #1;
    chk("full_cnt_31", 32'(busy_cnt), 32'd31);

    // Two-port writes clear two registers; count drops by 2 the next cycle
    wr(0, 5'd1, 32'h101); wr(1, 5'd2, 32'h202); rd(0, 5'd1); rd(1, 5'd2);
    #1;
    chk("clr2_busy_masked", 32'(rd_busy), 32'h0);
    chk("clr2_cnt_same", 32'(busy_cnt), 32'd31);
    cyc(); idle();
    #1;
    chk("clr2_cnt_next", 32'(busy_cnt), 32'd29);
    chk("clr2_busy_after", 32'(rd_busy), 32'h0);
    chk("clr2_r2_data", rd_data[63:32], 32'h202);

    // Re-reserving a busy register keeps it busy, count unchanged
    rsv(5'd3); rd(0, 5'd3);
    #1;
    chk("rersv_r3_busy", 32'(rd_busy[0]), 32'h1);
    cyc(); idle();
    #1;
    chk("rersv_cnt", 32'(busy_cnt), 32'd29);

    // Writing a non-busy register leaves it non-busy
    wr(0, 5'd1, 32'h111); rd(0, 5'd1);
    cyc(); idle();
    #1;
    chk("nb_r1_busy", 32'(rd_busy[0]), 32'h0);
    chk("nb_r1_data", rd_data[31:0], 32'h111);
    chk("nb_cnt", 32'(busy_cnt), 32'd29);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
